// File: rtl/alu_writeback_unit.sv
// Writeback stage behind the ALU. It holds the architectural flags and resolves branches,
// and it buffers register-file writes in a 2-entry FIFO with a valid/ready write port.
module alu_writeback_unit #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 3,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_zero,
    input  logic                  in_negative,
    input  logic                  in_carry,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_flag_write,
    input  logic                  in_is_branch,
    input  logic [1:0]            in_cond,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  branch_valid,
    output logic                  branch_taken,
    output logic [7:0]            wb_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_head_addr, r_tail_addr;
    logic [DATA_WIDTH-1:0] r_head_data, r_tail_data;
    logic                  r_flag_z, r_flag_n, r_flag_c;
    logic                  r_branch_valid, r_branch_taken;
    logic [7:0]            r_wb_count;

    logic w_accept, w_rd_zero, w_enq, w_pop, w_cond_taken;

    // Handshake flags come straight from state so in_ready never sees wb_ready.
    assign in_ready  = (r_state != S_TWO);
    assign wb_valid  = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_rd_zero = (ZERO_REG_HARDWIRED != 0) && (in_rd == '0);
    assign w_enq     = w_accept && in_reg_write && !w_rd_zero;
    assign w_pop     = wb_valid && wb_ready;

    always_comb begin
        w_cond_taken = 1'b1;
        case (in_cond)
            2'b00:   w_cond_taken = 1'b1;
            2'b01:   w_cond_taken = in_zero;
            2'b10:   w_cond_taken = !in_zero;
            default: w_cond_taken = in_negative;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_head_addr <= '0;
            r_head_data <= '0;
            r_tail_addr <= '0;
            r_tail_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_enq) begin
                        r_head_addr <= in_rd;
                        r_head_data <= in_result;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    // Simultaneous push and pop: the incoming entry replaces the head directly.
                    case ({w_enq, w_pop})
                        2'b10: begin
                            r_tail_addr <= in_rd;
                            r_tail_data <= in_result;
                            r_state     <= S_TWO;
                        end
                        2'b01: r_state <= S_EMPTY;
                        2'b11: begin
                            r_head_addr <= in_rd;
                            r_head_data <= in_result;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_addr <= r_tail_addr;
                        r_head_data <= r_tail_data;
                        r_state     <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag_z       <= 1'b0;
            r_flag_n       <= 1'b0;
            r_flag_c       <= 1'b0;
            r_branch_valid <= 1'b0;
            r_branch_taken <= 1'b0;
            r_wb_count     <= 8'd0;
        end else begin
            if (w_accept && in_flag_write) begin
                r_flag_z <= in_zero;
                r_flag_n <= in_negative;
                r_flag_c <= in_carry;
            end
            r_branch_valid <= w_accept && in_is_branch;
            if (w_accept && in_is_branch)
                r_branch_taken <= w_cond_taken;
            if (w_pop)
                r_wb_count <= r_wb_count + 8'd1;
        end
    end

    assign wb_addr      = r_head_addr;
    assign wb_data      = r_head_data;
    assign flag_z       = r_flag_z;
    assign flag_n       = r_flag_n;
    assign flag_c       = r_flag_c;
    assign branch_valid = r_branch_valid;
    assign branch_taken = r_branch_taken;
    assign wb_count     = r_wb_count;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed bench for alu_writeback_unit. It covers the write FIFO, flags, branches,
// the hardwired register 0, and asynchronous reset.
module tb_alu_writeback_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_result = '0;
    logic       in_zero = 1'b0, in_negative = 1'b0, in_carry = 1'b0;
    logic [2:0] in_rd = '0;
    logic       in_reg_write = 1'b0, in_flag_write = 1'b0, in_is_branch = 1'b0;
    logic [1:0] in_cond = '0;
    logic       wb_valid, wb_ready = 1'b0;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       flag_z, flag_n, flag_c, branch_valid, branch_taken;
    logic [7:0] wb_count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    alu_writeback_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG_HARDWIRED(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_negative(in_negative), .in_carry(in_carry),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_flag_write(in_flag_write),
        .in_is_branch(in_is_branch), .in_cond(in_cond),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .branch_valid(branch_valid), .branch_taken(branch_taken), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rd, input logic [7:0] d,
                         input logic rw, input logic fw, input logic z, input logic n,
                         input logic c, input logic br, input logic [1:0] cond);
        in_valid = v; in_rd = rd; in_result = d; in_reg_write = rw; in_flag_write = fw;
        in_zero = z; in_negative = n; in_carry = c; in_is_branch = br; in_cond = cond;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        idle();
        wb_ready = 1'b0;
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        step();
        reset = 1'b0;
        tot_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else pass_cnt++;
        tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        tot_cnt++; if ({wb_addr, wb_data} !== 11'd0) $display("FAIL reset_wb_bus got %h want 0", {wb_addr, wb_data}); else pass_cnt++;
        tot_cnt++; if ({flag_z, flag_n, flag_c, branch_valid, branch_taken} !== 5'b0) $display("FAIL reset_flags_branch got %b want 00000", {flag_z, flag_n, flag_c, branch_valid, branch_taken}); else pass_cnt++;
        tot_cnt++; if (wb_count !== 8'd0) $display("FAIL reset_wb_count got %0d want 0", wb_count); else pass_cnt++;
    endtask

    task automatic test_single_write();
        do_reset();
        wb_ready = 1'b1;
        drive(1'b1, 3'd3, 8'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        idle();
        tot_cnt++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd3, 8'h2A}) $display("FAIL single_head got v=%b a=%0d d=%h want v=1 a=3 d=2a", wb_valid, wb_addr, wb_data); else pass_cnt++;
        step();
        tot_cnt++; if (wb_valid !== 1'b0) $display("FAIL single_drained got %b want 0", wb_valid); else pass_cnt++;
        tot_cnt++; if (wb_count !== 8'd1) $display("FAIL single_count got %0d want 1", wb_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 3'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        tot_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b want 1", in_ready); else pass_cnt++;
        drive(1'b1, 3'd2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        tot_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_two got %b want 0", in_ready); else pass_cnt++;
        drive(1'b1, 3'd3, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        step();
        tot_cnt++; if ({in_ready, wb_valid, wb_addr, wb_data} !== {1'b0, 1'b1, 3'd1, 8'h11}) $display("FAIL bp_hold got r=%b v=%b a=%0d d=%h want r=0 v=1 a=1 d=11", in_ready, wb_valid, wb_addr, wb_data); else pass_cnt++;
        wb_ready = 1'b1;
        step();
        tot_cnt++; if ({in_ready, wb_addr, wb_data} !== {1'b1, 3'd2, 8'h22}) $display("FAIL bp_second got r=%b a=%0d d=%h want r=1 a=2 d=22", in_ready, wb_addr, wb_data); else pass_cnt++;
        step();
        idle();
        tot_cnt++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd3, 8'h33}) $display("FAIL bp_third got v=%b a=%0d d=%h want v=1 a=3 d=33", wb_valid, wb_addr, wb_data); else pass_cnt++;
        step();
        tot_cnt++; if ({wb_valid, wb_count} !== {1'b0, 8'd3}) $display("FAIL bp_done got v=%b cnt=%0d want v=0 cnt=3", wb_valid, wb_count); else pass_cnt++;
    endtask

    task automatic test_flags();
        do_reset();
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        step();
        tot_cnt++; if ({flag_z, flag_n, flag_c} !== 3'b101) $display("FAIL flags_set got %b want 101", {flag_z, flag_n, flag_c}); else pass_cnt++;
        tot_cnt++; if (wb_valid !== 1'b0) $display("FAIL flags_noreg got %b want 0", wb_valid); else pass_cnt++;
        drive(1'b1, 3'd4, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        idle();
        tot_cnt++; if ({flag_z, flag_n, flag_c} !== 3'b101) $display("FAIL flags_hold got %b want 101", {flag_z, flag_n, flag_c}); else pass_cnt++;
    endtask

    task automatic test_branch();
        logic [1:0] conds [5]  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
        logic       zs    [5]  = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        logic       ns    [5]  = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        logic       exps  [5]  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, zs[i], ns[i], 1'b0, 1'b1, conds[i]);
            step();
            idle();
            tot_cnt++; if ({branch_valid, branch_taken} !== {1'b1, exps[i]}) $display("FAIL branch_%0d got v=%b t=%b want v=1 t=%b", i, branch_valid, branch_taken, exps[i]); else pass_cnt++;
            step();
            tot_cnt++; if ({branch_valid, branch_taken} !== {1'b0, exps[i]}) $display("FAIL branch_pulse_%0d got v=%b t=%b want v=0 t=%b", i, branch_valid, branch_taken, exps[i]); else pass_cnt++;
        end
    endtask

    task automatic test_blocked();
        do_reset();
        drive(1'b1, 3'd1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 3'd2, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 3'd3, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        step();
        idle();
        tot_cnt++; if ({flag_z, flag_n, flag_c, branch_valid} !== 4'b0000) $display("FAIL blocked_no_effect got %b want 0000", {flag_z, flag_n, flag_c, branch_valid}); else pass_cnt++;
        tot_cnt++; if ({wb_addr, wb_data} !== {3'd1, 8'h01}) $display("FAIL blocked_head got a=%0d d=%h want a=1 d=01", wb_addr, wb_data); else pass_cnt++;
    endtask

    task automatic test_zero_reg_push_pop();
        do_reset();
        wb_ready = 1'b1;
        drive(1'b1, 3'd0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        tot_cnt++; if ({wb_valid, in_ready} !== 2'b01) $display("FAIL zero_reg got v=%b r=%b want v=0 r=1", wb_valid, in_ready); else pass_cnt++;
        drive(1'b1, 3'd4, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        tot_cnt++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd4, 8'h44}) $display("FAIL pp_first got v=%b a=%0d d=%h want v=1 a=4 d=44", wb_valid, wb_addr, wb_data); else pass_cnt++;
        drive(1'b1, 3'd5, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        idle();
        tot_cnt++; if ({in_ready, wb_valid, wb_addr, wb_data} !== {1'b1, 1'b1, 3'd5, 8'h55}) $display("FAIL pp_swap got r=%b v=%b a=%0d d=%h want r=1 v=1 a=5 d=55", in_ready, wb_valid, wb_addr, wb_data); else pass_cnt++;
        step();
        tot_cnt++; if ({wb_valid, wb_count} !== {1'b0, 8'd2}) $display("FAIL pp_done got v=%b cnt=%0d want v=0 cnt=2", wb_valid, wb_count); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        wb_ready = 1'b1;
        drive(1'b1, 3'd6, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        step();
        idle();
        step();
        wb_ready = 1'b0;
        drive(1'b1, 3'd1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 3'd2, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        idle();
        tot_cnt++; if ({in_ready, wb_valid, flag_z, wb_count} !== {1'b0, 1'b1, 1'b1, 8'd1}) $display("FAIL ar_before got r=%b v=%b z=%b cnt=%0d want r=0 v=1 z=1 cnt=1", in_ready, wb_valid, flag_z, wb_count); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        tot_cnt++; if ({wb_valid, flag_z, flag_n, flag_c, wb_count} !== 12'd0) $display("FAIL ar_immediate got v=%b f=%b%b%b cnt=%0d want all 0", wb_valid, flag_z, flag_n, flag_c, wb_count); else pass_cnt++;
        #1 reset = 1'b0;
        wb_ready = 1'b1;
        step();
        tot_cnt++; if ({in_ready, wb_valid, wb_count} !== {1'b1, 1'b0, 8'd0}) $display("FAIL ar_after got r=%b v=%b cnt=%0d want r=1 v=0 cnt=0", in_ready, wb_valid, wb_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_flags();
        test_branch();
        test_blocked();
        test_zero_reg_push_pop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
